// File: rtl/vfpu_align_pkg.sv
// Shared defaults and payload layout for the FMA addend alignment shifter.
package vfpu_align_pkg;

  localparam int FRAC_W_DEF  = 24;
  localparam int MAX_SHF_DEF = 74;
  localparam int SHF_W_DEF   = 7;
  localparam int TAG_W_DEF   = 4;

  // Window width: the fraction sits on top of MAX_SHF guard positions.
  function automatic int out_w(input int frac_w, input int max_shf);
    return frac_w + max_shf;
  endfunction

  localparam int OUT_W_DEF = out_w(FRAC_W_DEF, MAX_SHF_DEF);

  // Stage payload in the default configuration.
  // res holds the coarse-shifted window. shf_lo is the pending fine shift.
  // sticky is set when the beat overflowed with a nonzero fraction.
  typedef struct packed {
    logic [OUT_W_DEF-1:0] res;
    logic [2:0]           shf_lo;
    logic                 inv;
    logic                 sticky;
    logic [TAG_W_DEF-1:0] tag;
  } align_pay_t;

endpackage

// File: rtl/align_shf_stage.sv
// Generic enable/valid pipeline register carrying an arbitrary payload.
import vfpu_align_pkg::*;

module align_shf_stage #(
  parameter type pay_t = align_pay_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic en,
  input  logic vld_d,
  input  pay_t pay_d,
  output logic vld_q,
  output pay_t pay_q
);

  // Valid clears on flush. Payload only loads when the stage advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      pay_q <= '0;
    end else begin
      if (en) pay_q <= pay_d;
      if (flush)   vld_q <= 1'b0;
      else if (en) vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/align_shf_pipe.sv
// Two-stage addend alignment shifter.
// Stage A does the coarse shift (a multiple of 8). Stage B does the fine
// shift, saturation and inversion.
import vfpu_align_pkg::*;

module align_shf_pipe #(
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int MAX_SHF = MAX_SHF_DEF,
  parameter int SHF_W   = SHF_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  localparam int OUT_W  = out_w(FRAC_W, MAX_SHF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [SHF_W-1:0]  in_shf,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_res,
  output logic              out_sticky,
  output logic [TAG_W-1:0]  out_tag
);

  if ((1 << SHF_W) <= MAX_SHF) begin : g_bad_shf_w
    $error("align_shf_pipe: SHF_W too narrow for MAX_SHF");
  end
  if (SHF_W < 4) begin : g_bad_shf_min
    $error("align_shf_pipe: SHF_W must be at least 4");
  end

  typedef struct packed {
    logic [OUT_W-1:0] res;
    logic [2:0]       shf_lo;
    logic             inv;
    logic             sticky;
    logic [TAG_W-1:0] tag;
  } pay_t;

  typedef struct packed {
    logic [OUT_W-1:0] res;
    logic             sticky;
    logic [TAG_W-1:0] tag;
  } out_t;

  logic v_a, v_b, en_a, en_b;
  pay_t pay_a_d, pay_a_q;
  out_t pay_b_d, pay_b_q;
  logic [SHF_W-1:0] coarse;
  logic             sat;

  // Bubbles collapse: a stage advances when it is empty or downstream moves.
  assign en_b     = !v_b || out_ready;
  assign en_a     = !v_a || en_b;
  assign in_ready = en_a && !flush && !rst;

  // Coarse shift plus overflow detection.
  // An overflowed beat with a nonzero fraction is marked through sticky and
  // zeroed in stage B. With a zero fraction the window is already zero.
  always_comb begin
    pay_a_d        = '0;
    coarse         = {in_shf[SHF_W-1:3], 3'b000};
    sat            = in_shf > SHF_W'(MAX_SHF);
    pay_a_d.res    = sat ? '0 : ({in_frac, {MAX_SHF{1'b0}}} >> coarse);
    pay_a_d.shf_lo = sat ? 3'd0 : in_shf[2:0];
    pay_a_d.inv    = in_inv;
    pay_a_d.sticky = sat && (|in_frac);
    pay_a_d.tag    = in_tag;
  end

  align_shf_stage #(.pay_t(pay_t)) u_stg_a (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .en    (en_a),
    .vld_d (in_valid && in_ready),
    .pay_d (pay_a_d),
    .vld_q (v_a),
    .pay_q (pay_a_q)
  );

  // Fine shift, saturation and inversion. Sticky is never inverted.
  always_comb begin
    pay_b_d        = '0;
    pay_b_d.res    = (pay_a_q.sticky ? '0 : (pay_a_q.res >> pay_a_q.shf_lo))
                     ^ {OUT_W{pay_a_q.inv}};
    pay_b_d.sticky = pay_a_q.sticky;
    pay_b_d.tag    = pay_a_q.tag;
  end

  align_shf_stage #(.pay_t(out_t)) u_stg_b (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .en    (en_b),
    .vld_d (v_a),
    .pay_d (pay_b_d),
    .vld_q (v_b),
    .pay_q (pay_b_q)
  );

  assign out_valid  = v_b;
  assign out_res    = pay_b_q.res;
  assign out_sticky = pay_b_q.sticky;
  assign out_tag    = pay_b_q.tag;

endmodule

// File: tb/tb_align_shf_pipe.sv
// Self-checking bench for align_shf_pipe in its default configuration.
module tb_align_shf_pipe;

  localparam int FW = 24, MS = 74, SW = 7, TW = 4, OW = 98;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic          in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic [FW-1:0] in_frac = '0;
  logic [SW-1:0] in_shf = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid, out_sticky;
  logic [OW-1:0] out_res;
  logic [TW-1:0] out_tag;

  int checks = 0, errors = 0;

  align_shf_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_frac(in_frac), .in_shf(in_shf), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_sticky(out_sticky), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] frac;
    logic [SW-1:0] shf;
    logic          inv;
    logic [OW-1:0] res;
    logic          stk;
  } vec_t;

  typedef struct {
    logic [OW-1:0] res;
    logic          stk;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: one whole-window shift, then saturation and inversion rules.
  function automatic exp_t model(input logic [FW-1:0] f, input int s, input logic iv,
                                 input logic [TW-1:0] t);
    exp_t e;
    logic [OW-1:0] win;
    win = {f, {MS{1'b0}}};
    if (s > MS) begin
      e.res = '0;
      e.stk = (f != 0);
    end else begin
      e.res = win >> s;
      e.stk = 1'b0;
    end
    if (iv) e.res = ~e.res;
    e.tag = t;
    return e;
  endfunction

  logic          held = 1'b0;
  logic [OW-1:0] held_res;
  logic          held_stk;
  logic [TW-1:0] held_tag;

  // One cycle of streaming stimulus with scoreboard and stall-hold checking.
  task automatic cyc(input logic v, input logic [FW-1:0] f, input logic [SW-1:0] s,
                     input logic iv, input logic [TW-1:0] t, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_frac = f; in_shf = s; in_inv = iv; in_tag = t; out_ready = ordy;
    #1;
    if (held)
      chk("stall_hold", {out_valid, out_sticky, out_tag, out_res},
          {1'b1, held_stk, held_tag, held_res});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_res", out_res, e.res);
        chk("sb_stk_tag", {out_sticky, out_tag}, {e.stk, e.tag});
      end
    end
    held = out_valid && !out_ready;
    held_res = out_res; held_stk = out_sticky; held_tag = out_tag;
    if (in_valid && in_ready) sb.push_back(model(f, int'(s), iv, t));
  endtask

  vec_t tbl[8];
  int   nvld;

  initial begin
    tbl[0] = '{24'hFFFFFF, 7'd0,   1'b0, 98'hFFFFFF << 74,               1'b0};
    tbl[1] = '{24'hFFFFFF, 7'd74,  1'b0, 98'hFFFFFF,                     1'b0};
    tbl[2] = '{24'hFFFFFF, 7'd74,  1'b1, ~98'hFFFFFF,                    1'b0};
    tbl[3] = '{24'h800001, 7'd37,  1'b0, (98'd1 << 60) | (98'd1 << 37),  1'b0};
    tbl[4] = '{24'h000001, 7'd75,  1'b0, 98'd0,                          1'b1};
    tbl[5] = '{24'h123456, 7'd127, 1'b1, ~98'd0,                         1'b1};
    tbl[6] = '{24'h000000, 7'd100, 1'b0, 98'd0,                          1'b0};
    tbl[7] = '{24'h000001, 7'd74,  1'b1, ~98'd1,                         1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {out_valid, out_sticky, out_tag, out_res}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    // Directed vectors: one beat each, result expected two edges later.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1; in_frac = tbl[i].frac; in_shf = tbl[i].shf; in_inv = tbl[i].inv;
      in_tag = TW'(i); out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_res", i), out_res, tbl[i].res);
      chk($sformatf("vec%0d_stk_tag", i), {out_sticky, out_tag}, {tbl[i].stk, TW'(i)});
    end
    @(negedge clk);

    // Shift sweep 0..74 back to back, then random handshakes across all shifts.
    for (int s = 0; s <= MS; s++)
      cyc(1, FW'($urandom), SW'(s), 1'($urandom), TW'(s), 1);
    for (int n = 0; n < 600; n++)
      cyc(1'($urandom), FW'($urandom), SW'($urandom), 1'($urandom), TW'($urandom),
          ($urandom_range(0, 3) != 0));
    for (int n = 0; n < 6; n++) cyc(0, '0, '0, 0, '0, 1);
    chk("sb_drained", sb.size(), 0);
    held = 1'b0;

    // Backpressure: tags 1,2 accepted, 3 held off while output is stalled.
    @(negedge clk);
    in_valid = 1; in_frac = 24'hABCDEF; in_shf = 7'd5; in_inv = 0; in_tag = 4'd1;
    out_ready = 0;
    @(negedge clk); in_tag = 4'd2;
    @(negedge clk); in_tag = 4'd3;
    #1;
    held_res = out_res;
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_hold", {out_valid, out_tag, out_res}, {1'b1, 4'd1, held_res});
      @(negedge clk);
      #1;
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_tag1", {out_valid, out_tag}, {1'b1, 4'd1});
    @(negedge clk); in_valid = 0; #1;
    chk("bp_tag2", {out_valid, out_tag}, {1'b1, 4'd2});
    @(negedge clk); #1;
    chk("bp_tag3", {out_valid, out_tag}, {1'b1, 4'd3});
    @(negedge clk); #1;
    chk("bp_empty", out_valid, 0);

    // Flush with two beats in flight and a concurrent beat.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      out_ready = 0; in_valid = 1; in_frac = 24'h00F00D; in_shf = 7'd3; in_tag = 4'd5;
      @(negedge clk); in_tag = 4'd6;
      @(negedge clk); in_tag = 4'd7;
      if (pass == 0) flush = 1; else rst = 1;
      #1;
      chk("fl_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 0; rst = 0; in_valid = 0; out_ready = 1;
      #1;
      chk("fl_out_valid", out_valid, 0);
      if (pass == 1) chk("rst_mid_outs", {out_sticky, out_tag, out_res}, '0);
      nvld = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); #1;
        if (out_valid) nvld++;
      end
      chk("fl_no_emerge", nvld, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
